// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: request/response front end for the combinational ALU.
// Latches one operation, runs it 1..16 times with the result fed back into
// operand A, and returns the final result with flags and a sticky carry.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a request; ALU ports hold their last values
// EXEC  | one ALU iteration per cycle until the remaining count hits zero
// RESP  | response registered and presented until the consumer takes it
module alu_cmd_driver #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [n-1:0] req_a,
  input  logic [n-1:0] req_b,
  input  logic [3:0]   req_count,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [2:0]   alu_opcode,
  input  logic [n-1:0] alu_result,
  input  logic         alu_z,
  input  logic         alu_c_flag,
  input  logic         alu_c_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_result,
  output logic         rsp_z,
  output logic         rsp_c_flag,
  output logic         rsp_c_out,
  output logic [4:0]   rsp_iters,
  output logic [15:0]  done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  remaining;
  logic [4:0]  iter_cnt;
  logic        sticky_c;
  logic [4:0]  iter_inc;
  logic        sticky_inc;

  // Iteration count and sticky carry including the ALU output of this cycle.
  always_comb begin
    iter_inc   = iter_cnt + 5'd1;
    sticky_inc = sticky_c | alu_c_out;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)         state_nxt = EXEC;
      EXEC:    if (remaining == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  // Operand latch, feedback iteration, response capture and completion count.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      remaining  <= '0;
      iter_cnt   <= '0;
      sticky_c   <= 1'b0;
      rsp_result <= '0;
      rsp_z      <= 1'b0;
      rsp_c_flag <= 1'b0;
      rsp_c_out  <= 1'b0;
      rsp_iters  <= '0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_opcode <= req_op;
            alu_a      <= req_a;
            alu_b      <= req_b;
            remaining  <= req_count;
            iter_cnt   <= '0;
            sticky_c   <= 1'b0;
          end
        end
        EXEC: begin
          sticky_c <= sticky_inc;
          iter_cnt <= iter_inc;
          if (remaining != 4'd0) begin
            alu_a     <= alu_result;
            remaining <= remaining - 4'd1;
          end else begin
            rsp_result <= alu_result;
            rsp_z      <= alu_z;
            rsp_c_flag <= alu_c_flag;
            rsp_c_out  <= sticky_inc;
            rsp_iters  <= iter_inc;
          end
        end
        RESP: begin
          if (rsp_ready) done_count <= done_count + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: drives alu_cmd_driver with a behavioural ALU attached,
// predicts each response into a queue at issue time and compares on output.
module tb_alu_cmd_driver;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic [3:0]   req_count;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_result;
  logic         alu_z;
  logic         alu_c_flag;
  logic         alu_c_out;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_z;
  logic         rsp_c_flag;
  logic         rsp_c_out;
  logic [4:0]   rsp_iters;
  logic [15:0]  done_count;

  always #5 clk = ~clk;

  alu_cmd_driver #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_count  (req_count),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_c_flag (alu_c_flag),
    .alu_c_out  (alu_c_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_z      (rsp_z),
    .rsp_c_flag (rsp_c_flag),
    .rsp_c_out  (rsp_c_out),
    .rsp_iters  (rsp_iters),
    .done_count (done_count)
  );

  // Behavioural ALU: (N+1)-bit result, top bit is C_out.
  function automatic logic [N:0] alu_full(input logic [2:0] op,
                                          input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N:0] r;
    r = '0;
    case (op)
      3'b000: r = {1'b0, a} + {1'b0, b};
      3'b001: r = {1'b0, a} - {1'b0, b};
      3'b010: r = {1'b0, a & b};
      3'b011: r = {1'b0, a | b};
      3'b100: r = {1'b0, a ^ b};
      3'b101: r[0] = (a > b);
      3'b110: r = {a, 1'b0};
      default: r = {b, 1'b0};
    endcase
    return r;
  endfunction

  logic [N:0] alu_full_out;
  assign alu_full_out = alu_full(alu_opcode, alu_a, alu_b);
  assign alu_result   = alu_full_out[N-1:0];
  assign alu_c_out    = alu_full_out[N];
  assign alu_z        = (alu_full_out[N-1:0] == '0);
  assign alu_c_flag   = (alu_a > alu_b);

  typedef struct {
    logic [N-1:0] result;
    logic         z;
    logic         c_flag;
    logic         c_out;
    logic [4:0]   iters;
    logic [N-1:0] a_last;
    logic [N-1:0] b;
    logic [2:0]   op;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         last_exp;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [15:0]  exp_done = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [2:0] op, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [3:0] k);
    exp_t       e;
    logic [N:0] r;
    logic [N-1:0] cur_a;
    cur_a    = a;
    e.c_out  = 1'b0;
    e.result = '0;
    e.z      = 1'b0;
    e.c_flag = 1'b0;
    e.a_last = a;
    for (int i = 0; i <= int'(k); i++) begin
      r        = alu_full(op, cur_a, b);
      e.a_last = cur_a;
      e.c_out  = e.c_out | r[N];
      e.c_flag = (cur_a > b);
      e.result = r[N-1:0];
      e.z      = (r[N-1:0] == '0);
      cur_a    = r[N-1:0];
    end
    e.iters = 5'(k) + 5'd1;
    e.b     = b;
    e.op    = op;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [3:0] k);
    @(negedge clk);
    check_val("req_ready_before_issue", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_count = k;
    push_expected(op, a, b, k);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic collect(input int k);
    int cycles;
    cycles = 0;
    while (!rsp_valid && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_val("rsp_latency", cycles, k + 1);
    if (sb_q.size() == 0) begin
      check_val("scoreboard_nonempty", 0, 1);
    end else begin
      last_exp = sb_q.pop_front();
      check_val("rsp_valid",   rsp_valid,  1);
      check_val("rsp_result",  rsp_result, last_exp.result);
      check_val("rsp_z",       rsp_z,      last_exp.z);
      check_val("rsp_c_flag",  rsp_c_flag, last_exp.c_flag);
      check_val("rsp_c_out",   rsp_c_out,  last_exp.c_out);
      check_val("rsp_iters",   rsp_iters,  last_exp.iters);
      check_val("req_ready_in_resp", req_ready, 0);
    end
  endtask

  task automatic release_rsp(input int delay);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    exp_done  = exp_done + 16'd1;
    check_val("done_count",         done_count, exp_done);
    check_val("rsp_valid_dropped",  rsp_valid,  0);
    check_val("req_ready_after_rsp", req_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_count = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_req_ready",  req_ready,  1);
    check_val("reset_rsp_valid",  rsp_valid,  0);
    check_val("reset_alu_a",      alu_a,      0);
    check_val("reset_alu_b",      alu_b,      0);
    check_val("reset_alu_opcode", alu_opcode, 0);
    check_val("reset_rsp_result", rsp_result, 0);
    check_val("reset_rsp_iters",  rsp_iters,  0);
    check_val("reset_done_count", done_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: simple add
    issue(3'b000, 8'h05, 8'h03, 4'd0);
    collect(0);
    check_val("t1_result", rsp_result, 8'h08);
    check_val("t1_c_flag", rsp_c_flag, 1);
    check_val("t1_c_out",  rsp_c_out,  0);
    check_val("t1_iters",  rsp_iters,  1);
    release_rsp(0);

    // 2: iterated add with a carry in the middle
    issue(3'b000, 8'h80, 8'h40, 4'd3);
    collect(3);
    check_val("t2_result", rsp_result, 8'h80);
    check_val("t2_c_out",  rsp_c_out,  1);
    check_val("t2_c_flag", rsp_c_flag, 0);
    check_val("t2_z",      rsp_z,      0);
    check_val("t2_iters",  rsp_iters,  4);
    release_rsp(1);

    // 3: subtract to zero
    issue(3'b001, 8'h03, 8'h03, 4'd0);
    collect(0);
    check_val("t3_result", rsp_result, 8'h00);
    check_val("t3_z",      rsp_z,      1);
    check_val("t3_c_flag", rsp_c_flag, 0);
    check_val("t3_c_out",  rsp_c_out,  0);
    release_rsp(0);

    // 4: shift A with carry out on the first pass
    issue(3'b110, 8'h81, 8'h00, 4'd1);
    collect(1);
    check_val("t4_result", rsp_result, 8'h04);
    check_val("t4_c_out",  rsp_c_out,  1);
    check_val("t4_iters",  rsp_iters,  2);
    release_rsp(0);

    // 5: backpressure with a competing request held on the input
    issue(3'b000, 8'h10, 8'h20, 4'd2);
    collect(2);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'b100;
    req_a     = 8'hAA;
    req_b     = 8'h55;
    req_count = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_val("bp_rsp_valid",  rsp_valid,  1);
      check_val("bp_req_ready",  req_ready,  0);
      check_val("bp_rsp_result", rsp_result, last_exp.result);
      check_val("bp_rsp_iters",  rsp_iters,  last_exp.iters);
      check_val("bp_alu_a",      alu_a,      last_exp.a_last);
      check_val("bp_alu_b",      alu_b,      last_exp.b);
      check_val("bp_alu_opcode", alu_opcode, last_exp.op);
    end
    @(negedge clk);
    req_valid = 1'b0;
    release_rsp(0);
    issue(3'b011, 8'h0F, 8'hF0, 4'd0);
    collect(0);
    check_val("t5_new_result", rsp_result, 8'hFF);
    release_rsp(0);

    // random mix over all opcodes
    for (int t = 0; t < 16; t++) begin
      logic [2:0]   op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [3:0]   k;
      op = 3'($urandom_range(0, 7));
      a  = N'($urandom);
      b  = N'($urandom);
      k  = 4'($urandom_range(0, 5));
      if (t == 15) k = 4'd15;
      issue(op, a, b, k);
      collect(int'(k));
      release_rsp(int'($urandom_range(0, 2)));
    end

    // 6: reset during the 6th EXEC cycle of a 16-iteration request
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'b000;
    req_a     = 8'h11;
    req_b     = 8'h22;
    req_count = 4'd15;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_req_ready",  req_ready,  1);
    check_val("rst_rsp_valid",  rsp_valid,  0);
    check_val("rst_alu_a",      alu_a,      0);
    check_val("rst_alu_b",      alu_b,      0);
    check_val("rst_alu_opcode", alu_opcode, 0);
    check_val("rst_rsp_result", rsp_result, 0);
    check_val("rst_rsp_z",      rsp_z,      0);
    check_val("rst_rsp_c_flag", rsp_c_flag, 0);
    check_val("rst_rsp_c_out",  rsp_c_out,  0);
    check_val("rst_rsp_iters",  rsp_iters,  0);
    check_val("rst_done_count", done_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_done = '0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check_val("no_rsp_after_rst", seen, 0);
    check_val("done_after_rst", done_count, 0);
    issue(3'b000, 8'h01, 8'h01, 4'd0);
    collect(0);
    check_val("t6_result", rsp_result, 8'h02);
    release_rsp(0);

    check_val("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential command-issuing front end for the team's combinational ALU (`n`-bit A/B, 3-bit OpCode, Result, Z_flag, C_flag, C_out).
- Accepts an operation request over a valid/ready handshake and drives the ALU operand and opcode ports from registers.
- Optionally re-applies the operation up to 16 times, feeding each result back as operand A.
- Captures the result and flags and returns them over a valid/ready response channel.
- Sits between a controller or testbench sequencer and the ALU instance.

## Interface

- `n`, 8, operand/result width; must match the attached ALU.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle, can accept.
- `req_op` in 3: ALU opcode; all 8 codes are legal.
- `req_a`, `req_b` in n: initial operands.
- `req_count` in 4: extra iterations k; total iterations = k+1 (1..16).
- `alu_a`, `alu_b` out n: to ALU A, B.
- `alu_opcode` out 3: to ALU OpCode.
- `alu_result` in n: from ALU Result.
- `alu_z`, `alu_c_flag`, `alu_c_out` in 1: from ALU Z_flag, C_flag, C_out.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_result` out n: final result.
- `rsp_z`, `rsp_c_flag` out 1: flags of the last iteration.
- `rsp_c_out` out 1: OR of `alu_c_out` over all iterations (sticky).
- `rsp_iters` out 5: iterations executed, k+1.
- `done_count` out 16: completed responses; wraps from 0xFFFF to 0.

## Operation

FSM states are IDLE, EXEC and RESP.

- **IDLE**
  - `req_ready`=1.
  - On an edge with `req_valid`=1: latch `req_op`, `req_a`, `req_b` and `req_count` into `alu_opcode`, `alu_a`, `alu_b` and the remaining counter.
  - Clear the sticky carry and the iteration counter.
  - Go to EXEC.
- **EXEC** (one cycle per iteration; ALU outputs settle within the cycle)
  - At each edge, sample `alu_result` and the flags.
  - OR `alu_c_out` into the sticky carry.
  - Increment the iteration counter.
  - If remaining ≠ 0: `alu_a` <= `alu_result`, remaining <= remaining−1, stay in EXEC.
  - Otherwise: load the `rsp_*` registers and go to RESP.
  - `alu_b` and `alu_opcode` hold constant for the whole request.
- **RESP**
  - `rsp_valid`=1, `req_ready`=0.
  - On an edge with `rsp_ready`=1: increment `done_count`, drop `rsp_valid`, go to IDLE.
- All `rsp_*` outputs are registered and stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- `alu_*` outputs hold their last values in IDLE and RESP.
- Repeated opcode 111 (B<<1) yields the same result on every iteration, because B is never updated. This is the intended behaviour.

## Timing

- Reset values:
  - FSM = IDLE, so `req_ready`=1.
  - `rsp_valid`=0.
  - `alu_a`, `alu_b`, `alu_opcode` = 0.
  - `rsp_result`, `rsp_z`, `rsp_c_flag`, `rsp_c_out`, `rsp_iters` = 0.
  - `done_count` = 0.
- Latency: a request accepted at edge E0 produces `rsp_valid`=1 after edge E0+k+1.
- Throughput:
  - Response transfer at edge Er puts the block in IDLE, with `req_ready`=1 during the cycle after Er.
  - The earliest next accept is edge Er+1.
  - There is no same-cycle response/request overlap.
- `req_valid` while the block is busy is ignored; it is neither latched nor queued.
- `rsp_ready` asserted outside RESP has no effect.
- Reset at any point, mid-EXEC or in RESP:
  - The in-flight request is dropped and no response is produced.
  - All outputs return to their reset values on that edge.
- Width rules:
  - Results are n bits, with no extension.
  - The iteration counter is 5 bits, so the maximum `rsp_iters` is 16.
  - `done_count` wraps modulo 2^16.

## Test plan

The bench attaches a behavioural ALU: add, sub, and, or, xor, A>B, A<<1, B<<1; C_out = bit n of the (n+1)-bit result; C_flag = A>B; Z = (Result==0).

1. op=000, A=0x05, B=0x03, k=0 -> after 1 cycle: `rsp_result`=0x08, `rsp_z`=0, `rsp_c_flag`=1, `rsp_c_out`=0, `rsp_iters`=1.
2. op=000, A=0x80, B=0x40, k=3 -> iterations give 0xC0, 0x00 (carry), 0x40, 0x80; `rsp_valid` after 4 cycles with `rsp_result`=0x80, `rsp_c_out`=1 (sticky), `rsp_c_flag`=0, `rsp_z`=0, `rsp_iters`=4.
3. op=001, A=0x03, B=0x03, k=0 -> `rsp_result`=0x00, `rsp_z`=1, `rsp_c_flag`=0, `rsp_c_out`=0.
4. op=110, A=0x81, k=1 -> iterations give 0x02 (carry out), then 0x04; `rsp_result`=0x04, `rsp_c_out`=1, `rsp_iters`=2.
5. Backpressure: hold `rsp_ready`=0 for 5 cycles with `req_valid`=1 and new operands.
   - `rsp_*` stay stable and `req_ready`=0.
   - The second request is not latched.
   - After `rsp_ready`=1: `done_count` increments by 1, `req_ready`=1 the next cycle, and a new request completes correctly.
6. Start op=000 with k=15 and assert `rst` during the 6th EXEC cycle.
   - All outputs return to 0, no `rsp_valid`, `done_count` stays unchanged at 0.
   - A following request (0x01+0x01, k=0) returns 0x02.
